// File: rtl/k_stream_pkg.sv
// rtl/k_stream_pkg.sv - shared state type, default widths, lane slicing and weight image for k_stream_out
package k_stream_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 13;
   localparam int IND_W  = 7;

   typedef enum logic [1:0] {IDLE, CALC, STREAM, DRAIN} k_state_e;

   function automatic int k_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Weight image: lane index in the upper field, word address in the lower ten bits.
   function automatic logic [31:0] k_rom_word(input int lane, input int addr);
      return 32'((lane << 10) | (addr & 32'h3FF));
   endfunction

endpackage

`ifndef K_LANE
`define K_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

// File: rtl/k_lane_rom.sv
// rtl/k_lane_rom.sv - one DATA_W x 2**ADDR_W weight ROM lane, synchronous read, output held while ena=0
module k_lane_rom #(
   parameter int LANE   = 0,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] rdata
);
   import k_stream_pkg::*;

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         rdata <= '0;
      end else if (ena) begin
         rdata <= DATA_W'(k_rom_word(LANE, int'(addr)));
      end
   end

endmodule

// File: rtl/k_stream_out.sv
// rtl/k_stream_out.sv - kernel-weight streamer: FSM, base multiply, ROM bank, valid/last pipeline.
// Optional bound check on the kernel window enabled by K_BOUND_CHK_EN.
module k_stream_out #(
   parameter int NUM_LANES = 36,
   parameter int DATA_W    = k_stream_pkg::DATA_W,
   parameter int KSIZE     = 36,
   parameter int IND_W     = k_stream_pkg::IND_W,
   parameter int ADDR_W    = k_stream_pkg::ADDR_W
) (
   input  logic                        clk_in,
   input  logic                        rst_n,
   input  logic                        k_start,
   input  logic [IND_W-1:0]            k_ind,
   input  logic                        k_loop,
   input  logic                        k_rdy_in,
   output logic                        k_busy,
   output logic                        k_valid,
   output logic                        k_last,
   output logic [NUM_LANES*DATA_W-1:0] k_data,
   output logic                        k_err
);
   import k_stream_pkg::*;

   localparam int CNT_W  = k_clog2(KSIZE);
   localparam int PROD_W = IND_W + CNT_W + 1;

   k_state_e                    state_q, state_d;
   logic [IND_W-1:0]            ind_q;
   logic [ADDR_W-1:0]           base_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [CNT_W-1:0]            cnt_q;
   logic                        iss_q;
   logic                        iss_last_q;
   logic [PROD_W-1:0]           prod_full;
   logic [ADDR_W-1:0]           base_calc;
   logic                        bound_err;
   logic                        fire;
   logic                        last_cnt;
   logic [NUM_LANES*DATA_W-1:0] rom_bus;

   assign fire      = ~k_valid | k_rdy_in;
   assign last_cnt  = (cnt_q == CNT_W'(KSIZE - 1));
   assign prod_full = PROD_W'(ind_q) * PROD_W'(KSIZE);
   assign base_calc = ADDR_W'(prod_full);
   assign k_busy    = (state_q != IDLE);

`ifdef K_BOUND_CHK_EN
   logic [PROD_W:0] end_full;
   logic            err_q;

   // Uses the untruncated product so a base beyond the ROM is caught, not just a window straddling the top.
   assign end_full  = {1'b0, prod_full} + (PROD_W + 1)'(KSIZE - 1);
   assign bound_err = ((end_full >> ADDR_W) != '0);
   assign k_err     = err_q;

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state_q == CALC) && bound_err;
      end
   end
`else
   assign bound_err = 1'b0;
   assign k_err     = 1'b0;
`endif

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      k_lane_rom #(
         .LANE   (i),
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rom (
         .clk_in (clk_in),
         .rst_n  (rst_n),
         .ena    (fire),
         .addr   (addr_q),
         .rdata  (`K_LANE(rom_bus, i, DATA_W))
      );
   end

   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (k_start) state_d = CALC;
         CALC:    state_d = bound_err ? IDLE : STREAM;
         STREAM:  if (fire && last_cnt && !k_loop) state_d = DRAIN;
         DRAIN:   if (fire && k_valid && k_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Issue -> ROM register -> output register; every stage advances only on fire.
   always_ff @(posedge clk_in or posedge rst_n) begin
      if (rst_n) begin
         ind_q      <= '0;
         base_q     <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         iss_q      <= 1'b0;
         iss_last_q <= 1'b0;
         k_valid    <= 1'b0;
         k_last     <= 1'b0;
         k_data     <= '0;
      end else begin
         if (state_q == IDLE && k_start) begin
            ind_q <= k_ind;
         end
         if (state_q == CALC) begin
            base_q <= base_calc;
            addr_q <= base_calc;
            cnt_q  <= '0;
         end
         if (state_q == STREAM && fire) begin
            if (!last_cnt) begin
               addr_q <= addr_q + ADDR_W'(1);
               cnt_q  <= cnt_q + CNT_W'(1);
            end else if (k_loop) begin
               addr_q <= base_q;
               cnt_q  <= '0;
            end
         end
         if (fire) begin
            iss_q      <= (state_q == STREAM);
            iss_last_q <= (state_q == STREAM) && last_cnt;
            k_valid    <= iss_q;
            k_last     <= iss_last_q;
            k_data     <= rom_bus;
         end
      end
   end

endmodule

// File: tb/tb_k_stream_out.sv
// tb/tb_k_stream_out.sv - scoreboard bench for k_stream_out (ADDR_W=7 so the wrap case is reachable)
module tb_k_stream_out;
   localparam int NL = 36;
   localparam int DW = 16;
   localparam int KS = 36;
   localparam int IW = 7;
   localparam int AW = 7;

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic              k_start;
   logic [IW-1:0]     k_ind;
   logic              k_loop;
   logic              k_rdy_in;
   logic              k_busy;
   logic              k_valid;
   logic              k_last;
   logic [NL*DW-1:0]  k_data;
   logic              k_err;

   typedef struct {
      int addr;
      bit last;
   } beat_t;

   beat_t sb_q[$];
   int    tests   = 0;
   int    fails   = 0;
   int    acc_cnt = 0;

   always #5 clk_in = ~clk_in;

   k_stream_out #(
      .NUM_LANES (NL),
      .DATA_W    (DW),
      .KSIZE     (KS),
      .IND_W     (IW),
      .ADDR_W    (AW)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .k_start  (k_start),
      .k_ind    (k_ind),
      .k_loop   (k_loop),
      .k_rdy_in (k_rdy_in),
      .k_busy   (k_busy),
      .k_valid  (k_valid),
      .k_last   (k_last),
      .k_data   (k_data),
      .k_err    (k_err)
   );

   function automatic logic [NL*DW-1:0] exp_word(input int a);
      logic [NL*DW-1:0] w;
      for (int i = 0; i < NL; i++) w[i*DW +: DW] = DW'(i * 1024 + a);
      return w;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic push_pass(input int base);
      for (int c = 0; c < KS; c++) sb_q.push_back('{(base + c) % (1 << AW), c == KS - 1});
   endtask

   task automatic start_pass(input int ind);
      @(posedge clk_in); #1;
      k_start = 1'b1;
      k_ind   = IW'(ind);
      @(posedge clk_in); #1;
      k_start = 1'b0;
   endtask

   task automatic wait_acc(input string name, input int target);
      int n;
      n = 0;
      while (acc_cnt < target && n < 500) begin
         @(posedge clk_in);
         n++;
      end
      #1;
      check({name, "_acc_timeout"}, int'(n < 500), 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((k_busy || k_valid || sb_q.size() != 0) && n < 1000) begin
         @(posedge clk_in); #1;
         n++;
      end
      check({name, "_idle_timeout"}, int'(n < 1000), 1);
   endtask

   initial begin : monitor
      beat_t b;
      forever begin
         @(negedge clk_in);
         if (rst_n === 1'b0 && k_valid === 1'b1 && k_rdy_in === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL beat_unexpected: got lane0=%0h, want no beat", k_data[DW-1:0]);
            end else begin
               b = sb_q.pop_front();
               if (k_data !== exp_word(b.addr) || k_last !== b.last) begin
                  fails++;
                  $display("FAIL beat%0d: got lane0=%0h lane35=%0h last=%0b, want addr %0d last=%0b",
                           acc_cnt, k_data[DW-1:0], k_data[35*DW +: DW], k_last, b.addr, b.last);
               end
            end
            acc_cnt++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc0;
      int run;
      int n;
      rst_n    = 1'b1;
      k_start  = 1'b0;
      k_ind    = '0;
      k_loop   = 1'b0;
      k_rdy_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_ctrl", int'({k_busy, k_valid, k_last, k_err}), 0);
      check("rst_data", int'(k_data == '0), 1);
      rst_n = 1'b0;

      // 1: k_ind=2, addresses 72..107, word0 after T+3
      acc0 = acc_cnt;
      push_pass(72);
      start_pass(2);
      check("t1_busy_rise", int'(k_busy), 1);
      @(posedge clk_in); #1;
      check("t1_valid_T1", int'(k_valid), 0);
      @(posedge clk_in); #1;
      check("t1_valid_T2", int'(k_valid), 0);
      @(posedge clk_in); #1;
      check("t1_valid_T3", int'(k_valid), 1);
      wait_acc("t1", acc0 + KS);
      check("t1_busy_fall", int'({k_busy, k_valid}), 0);
      check("t1_beats", acc_cnt - acc0, KS);

      // 2: ready low for 3 cycles while word 9 is presented
      acc0 = acc_cnt;
      push_pass(72);
      start_pass(2);
      wait_acc("t2", acc0 + 9);
      k_rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in); #1;
         check("t2_hold_data", int'(k_data == exp_word(81)), 1);
         check("t2_hold_valid", int'(k_valid), 1);
      end
      k_rdy_in = 1'b1;
      wait_idle("t2");
      check("t2_beats", acc_cnt - acc0, KS);

      // 3: loop for two passes, then stop
      acc0 = acc_cnt;
      push_pass(72);
      push_pass(72);
      push_pass(72);
      k_loop = 1'b1;
      start_pass(2);
      n = 0;
      while (!k_valid && n < 20) begin
         @(posedge clk_in); #1;
         n++;
      end
      run = 0;
      n   = 0;
      while (k_valid && n < 400) begin
         if (acc_cnt - acc0 >= 80) k_loop = 1'b0;
         run++;
         @(posedge clk_in); #1;
         n++;
      end
      k_loop = 1'b0;
      check("t3_contig_run", run, 3 * KS);
      wait_idle("t3");
      check("t3_beats", acc_cnt - acc0, 3 * KS);

      // 4: k_start during STREAM is ignored
      acc0 = acc_cnt;
      push_pass(72);
      start_pass(2);
      wait_acc("t4", acc0 + 10);
      k_start = 1'b1;
      k_ind   = IW'(5);
      @(posedge clk_in); #1;
      k_start = 1'b0;
      wait_idle("t4");
      repeat (5) @(posedge clk_in);
      #1;
      check("t4_no_restart", int'({k_busy, k_valid}), 0);
      check("t4_beats", acc_cnt - acc0, KS);

      // 5: reset mid-pass, then a fresh pass from address 0
      acc0 = acc_cnt;
      push_pass(72);
      start_pass(2);
      wait_acc("t5", acc0 + 16);
      #2;
      rst_n = 1'b1;
      #1;
      check("t5_rst_ctrl", int'({k_busy, k_valid, k_last}), 0);
      check("t5_rst_data", int'(k_data == '0), 1);
      sb_q.delete();
      @(posedge clk_in); #1;
      rst_n = 1'b0;
      acc0 = acc_cnt;
      push_pass(0);
      start_pass(0);
      wait_idle("t5");
      check("t5_beats", acc_cnt - acc0, KS);

      // 6: k_ind=4 -> 144 exceeds the 7-bit ROM
      acc0 = acc_cnt;
`ifdef K_BOUND_CHK_EN
      start_pass(4);
      @(posedge clk_in); #1;
      check("t6_err_pulse", int'({k_err, k_busy}), 2);
      @(posedge clk_in); #1;
      check("t6_err_clear", int'(k_err), 0);
      repeat (4) @(posedge clk_in);
      #1;
      check("t6_no_valid", acc_cnt - acc0, 0);
`else
      push_pass(16);
      start_pass(4);
      wait_idle("t6");
      check("t6_beats", acc_cnt - acc0, KS);
      check("t6_err_tied", int'(k_err), 0);
`endif

      check("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
